adc_stream_reset_sequencer: RTL and testbench

//  Consumes the synchronized reset in the clk1 (stream) domain and sequences staged reset release for the
//  ADC-to-UDP datapath: sample FIFO, packetizer, UDP TX, then stream enable. A soft reset request drains an
//  in-flight UDP packet (to tlast or timeout) before re-asserting the staged resets, so no partial frame is emitted.

---
 rtl/adc_stream_reset_sequencer.sv | 166 ++++++++++++++++
 tb/tb_adc_stream_reset_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_stream_reset_sequencer.sv
// Staged reset release for the ADC-to-UDP stream path (FIFO -> packetizer -> UDP TX -> stream enable).
// A soft reset taken while a UDP packet is in flight drains it to tlast (or a timeout) before resetting.
// Optional build macro RST_SEQ_STATE_PORT_EN adds the seq_state_out[2:0] debug port.
module adc_stream_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned STAGE_GAP     = 8,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic        clk1_in,
  input  logic        reset_clk1,
  input  logic        soft_reset_in,
  input  logic        s_tvalid,
  input  logic        s_tready,
  input  logic        s_tlast,
  output logic        rst_fifo_out,
  output logic        rst_pkt_out,
  output logic        rst_tx_out,
  output logic        stream_en_out,
  output logic        seq_busy_out,
  output logic        drain_timeout_out,
  output logic [15:0] reset_count_out
`ifdef RST_SEQ_STATE_PORT_EN
  ,
  output logic [2:0]  seq_state_out
`endif
);

  localparam int unsigned MAX_HS = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned MAX_P  = (MAX_HS > DRAIN_TIMEOUT) ? MAX_HS : DRAIN_TIMEOUT;
  localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_REL_FIFO = 3'd1,
    ST_REL_PKT  = 3'd2,
    ST_REL_TX   = 3'd3,
    ST_RUN      = 3'd4,
    ST_DRAIN    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_pkt_q, in_pkt_d;
  logic [15:0]        count_q, count_d;
  logic               timeout_q, timeout_d;
  logic               rst_fifo_q, rst_fifo_d;
  logic               rst_pkt_q, rst_pkt_d;
  logic               rst_tx_q, rst_tx_d;
  logic               stream_en_q, stream_en_d;
  logic               busy_q, busy_d;
  logic               beat;
  logic               in_pkt_upd;

  // State register and registered outputs; reset lands every stage in HOLD.
  always_ff @(posedge clk1_in) begin
    if (reset_clk1) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      in_pkt_q    <= 1'b0;
      count_q     <= '0;
      timeout_q   <= 1'b0;
      rst_fifo_q  <= 1'b1;
      rst_pkt_q   <= 1'b1;
      rst_tx_q    <= 1'b1;
      stream_en_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_pkt_q    <= in_pkt_d;
      count_q     <= count_d;
      timeout_q   <= timeout_d;
      rst_fifo_q  <= rst_fifo_d;
      rst_pkt_q   <= rst_pkt_d;
      rst_tx_q    <= rst_tx_d;
      stream_en_q <= stream_en_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, per-state cycle counter, packet tracking and output decode from the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    timeout_d  = timeout_q;
    beat       = s_tvalid & s_tready;
    in_pkt_upd = beat ? ~s_tlast : in_pkt_q;

    case (state_q)
      ST_HOLD: begin
        if (soft_reset_in) begin
          cnt_d = '0;
        end else if (cnt_q >= CNT_W'(HOLD_CYCLES)) begin
          state_d = ST_REL_FIFO;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REL_FIFO, ST_REL_PKT, ST_REL_TX: begin
        if (soft_reset_in) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_W'(STAGE_GAP)) begin
          cnt_d = CNT_W'(1);
          case (state_q)
            ST_REL_FIFO: state_d = ST_REL_PKT;
            ST_REL_PKT:  state_d = ST_REL_TX;
            default:     begin state_d = ST_RUN; cnt_d = '0; end
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (soft_reset_in) begin
          count_d = (count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
          if (in_pkt_upd) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
      end
      ST_DRAIN: begin
        // A tlast beat wins over a coincident timeout.
        if (beat && s_tlast) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_W'(DRAIN_TIMEOUT)) begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase

    in_pkt_d    = (state_d == ST_HOLD) ? 1'b0 : in_pkt_upd;
    rst_fifo_d  = (state_d == ST_HOLD);
    rst_pkt_d   = (state_d == ST_HOLD) || (state_d == ST_REL_FIFO);
    rst_tx_d    = (state_d == ST_HOLD) || (state_d == ST_REL_FIFO) || (state_d == ST_REL_PKT);
    stream_en_d = (state_d == ST_RUN);
    busy_d      = (state_d != ST_RUN);
  end

  assign rst_fifo_out      = rst_fifo_q;
  assign rst_pkt_out       = rst_pkt_q;
  assign rst_tx_out        = rst_tx_q;
  assign stream_en_out     = stream_en_q;
  assign seq_busy_out      = busy_q;
  assign drain_timeout_out = timeout_q;
  assign reset_count_out   = count_q;
`ifdef RST_SEQ_STATE_PORT_EN
  assign seq_state_out     = state_q;
`endif

endmodule

// File: tb/tb_adc_stream_reset_sequencer.sv
// Scoreboard bench for adc_stream_reset_sequencer: stimulus tasks queue expected output values at
// absolute clock-edge indices; a negedge monitor pops and compares them.
module tb_adc_stream_reset_sequencer;

  localparam int S_FIFO  = 0;
  localparam int S_PKT   = 1;
  localparam int S_TX    = 2;
  localparam int S_EN    = 3;
  localparam int S_BUSY  = 4;
  localparam int S_TO    = 5;
  localparam int S_CNT   = 6;
  localparam int S_STATE = 7;

  logic        clk = 1'b0;
  logic        reset_clk1;
  logic        soft_reset_in;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic        rst_fifo_out;
  logic        rst_pkt_out;
  logic        rst_tx_out;
  logic        stream_en_out;
  logic        seq_busy_out;
  logic        drain_timeout_out;
  logic [15:0] reset_count_out;
`ifdef RST_SEQ_STATE_PORT_EN
  logic [2:0]  seq_state_out;
`endif

  adc_stream_reset_sequencer dut (
    .clk1_in          (clk),
    .reset_clk1       (reset_clk1),
    .soft_reset_in    (soft_reset_in),
    .s_tvalid         (s_tvalid),
    .s_tready         (s_tready),
    .s_tlast          (s_tlast),
    .rst_fifo_out     (rst_fifo_out),
    .rst_pkt_out      (rst_pkt_out),
    .rst_tx_out       (rst_tx_out),
    .stream_en_out    (stream_en_out),
    .seq_busy_out     (seq_busy_out),
    .drain_timeout_out(drain_timeout_out),
    .reset_count_out  (reset_count_out)
`ifdef RST_SEQ_STATE_PORT_EN
    ,
    .seq_state_out    (seq_state_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    int          sel;
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  // Edge index of the most recent posedge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] get_sig(input int sel);
    case (sel)
      S_FIFO:  return 16'(rst_fifo_out);
      S_PKT:   return 16'(rst_pkt_out);
      S_TX:    return 16'(rst_tx_out);
      S_EN:    return 16'(stream_en_out);
      S_BUSY:  return 16'(seq_busy_out);
      S_TO:    return 16'(drain_timeout_out);
      S_CNT:   return reset_count_out;
`ifdef RST_SEQ_STATE_PORT_EN
      S_STATE: return 16'(seq_state_out);
`endif
      default: return 16'hDEAD;
    endcase
  endfunction

  // Insert keeping the queue ordered by edge index.
  task automatic exp_at(input int at, input int sel, input logic [15:0] val, input string tag);
    exp_t e;
    int   i;
    e.at = at; e.sel = sel; e.val = val; e.tag = tag;
    i = 0;
    while (i < q.size() && q[i].at <= at) i++;
    q.insert(i, e);
  endtask

  task automatic exp_rst_all(input int at, input string t);
    exp_at(at, S_FIFO, 16'd1, {t, "_rst_fifo"});
    exp_at(at, S_PKT,  16'd1, {t, "_rst_pkt"});
    exp_at(at, S_TX,   16'd1, {t, "_rst_tx"});
    exp_at(at, S_EN,   16'd0, {t, "_stream_en"});
    exp_at(at, S_BUSY, 16'd1, {t, "_busy"});
  endtask

  // Staged release where edge b is the first edge with reset and soft request sampled low.
  task automatic exp_release(input int b, input string t);
    exp_at(b + 15, S_FIFO, 16'd1, {t, "_fifo_held"});
    exp_at(b + 16, S_FIFO, 16'd0, {t, "_fifo_rel"});
    exp_at(b + 16, S_PKT,  16'd1, {t, "_pkt_held"});
    exp_at(b + 23, S_PKT,  16'd1, {t, "_pkt_held2"});
    exp_at(b + 24, S_PKT,  16'd0, {t, "_pkt_rel"});
    exp_at(b + 24, S_TX,   16'd1, {t, "_tx_held"});
    exp_at(b + 31, S_TX,   16'd1, {t, "_tx_held2"});
    exp_at(b + 32, S_TX,   16'd0, {t, "_tx_rel"});
    exp_at(b + 32, S_EN,   16'd0, {t, "_en_low"});
    exp_at(b + 39, S_EN,   16'd0, {t, "_en_low2"});
    exp_at(b + 39, S_BUSY, 16'd1, {t, "_busy_hi"});
    exp_at(b + 40, S_EN,   16'd1, {t, "_en_rise"});
    exp_at(b + 40, S_BUSY, 16'd0, {t, "_busy_fall"});
    exp_at(b + 40, S_CNT,  16'(exp_cnt), {t, "_count"});
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    exp_t cur;
    while (q.size() > 0 && q[0].at <= cyc) begin
      cur = q.pop_front();
      if (cur.at == cyc) chk(cur.tag, get_sig(cur.sel), cur.val);
      else               chk({cur.tag, "_missed"}, 16'(cyc), 16'(cur.at));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_q(input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (q.size() > 0) begin
      chk("scoreboard_wait", 16'(q.size()), 16'd0);
      q.delete();
    end
  endtask

  initial begin
    int e, b, t, r;
    reset_clk1    = 1'b1;
    soft_reset_in = 1'b0;
    s_tvalid      = 1'b0;
    s_tready      = 1'b0;
    s_tlast       = 1'b0;

    // 1: block reset then plain release
    repeat (2) step();
    exp_rst_all(cyc + 1, "t1_reset");
    exp_at(cyc + 1, S_TO,  16'd0, "t1_reset_timeout");
    exp_at(cyc + 1, S_CNT, 16'd0, "t1_reset_count");
`ifdef RST_SEQ_STATE_PORT_EN
    exp_at(cyc + 1, S_STATE, 16'd0, "t1_reset_state");
`endif
    repeat (3) step();
    reset_clk1 = 1'b0;
    exp_release(cyc + 1, "t1");
    wait_q(60);

    // 2: idle soft pulse from RUN
    soft_reset_in = 1'b1;
    e = cyc + 1;
    exp_cnt++;
    exp_rst_all(e, "t2_soft");
    exp_at(e, S_CNT, 16'(exp_cnt), "t2_count");
    step();
    soft_reset_in = 1'b0;
    exp_release(cyc + 1, "t2");
    wait_q(60);

    // 3: soft reset mid-packet, drained by a tlast beat 20 cycles later
    s_tvalid = 1'b1; s_tready = 1'b1; s_tlast = 1'b0;
    repeat (3) step();
    s_tvalid = 1'b0;
    soft_reset_in = 1'b1;
    e = cyc + 1;
    t = e + 20;
    exp_cnt++;
    exp_at(e, S_EN,   16'd0, "t3_en_drop");
    exp_at(e, S_BUSY, 16'd1, "t3_busy");
    exp_at(e, S_FIFO, 16'd0, "t3_drain_fifo");
    exp_at(e, S_TX,   16'd0, "t3_drain_tx");
    exp_at(e, S_CNT,  16'(exp_cnt), "t3_count");
    exp_at(t - 1, S_FIFO, 16'd0, "t3_still_drain");
    exp_rst_all(t, "t3_tlast");
    exp_at(t, S_TO, 16'd0, "t3_no_timeout");
    exp_release(t + 1, "t3");
    step();
    soft_reset_in = 1'b0;
    repeat (19) step();
    s_tvalid = 1'b1; s_tready = 1'b1; s_tlast = 1'b1;
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    wait_q(80);

    // 4: stalled packet forces a drain timeout
    s_tvalid = 1'b1; s_tready = 1'b1; s_tlast = 1'b0;
    step();
    s_tready = 1'b0;
    soft_reset_in = 1'b1;
    e = cyc + 1;
    exp_cnt++;
    exp_at(e, S_EN,   16'd0, "t4_en_drop");
    exp_at(e, S_FIFO, 16'd0, "t4_drain_fifo");
    exp_at(e, S_CNT,  16'(exp_cnt), "t4_count");
    exp_at(e + 1023, S_FIFO, 16'd0, "t4_pre_timeout_fifo");
    exp_at(e + 1023, S_TO,   16'd0, "t4_pre_timeout_flag");
    exp_rst_all(e + 1024, "t4_timeout");
    exp_at(e + 1024, S_TO, 16'd1, "t4_timeout_flag");
    exp_release(e + 1025, "t4");
    exp_at(e + 1025 + 41, S_TO, 16'd1, "t4_flag_sticky");
    step();
    soft_reset_in = 1'b0;
    wait_q(1200);
    s_tvalid = 1'b0;

    // 5: soft request during REL_PKT restarts the sequence without counting
    soft_reset_in = 1'b1;
    e = cyc + 1;
    exp_cnt++;
    exp_at(e, S_FIFO, 16'd1, "t5_soft_run");
    exp_at(e, S_CNT,  16'(exp_cnt), "t5_count_run");
    step();
    soft_reset_in = 1'b0;
    b = cyc + 1;
    exp_at(b + 16, S_FIFO, 16'd0, "t5_fifo_rel");
    exp_at(b + 24, S_PKT,  16'd0, "t5_pkt_rel");
    exp_at(b + 26, S_FIFO, 16'd0, "t5_in_rel_pkt");
    exp_rst_all(b + 27, "t5_abort");
    exp_at(b + 27, S_CNT, 16'(exp_cnt), "t5_count_kept");
    exp_release(b + 28, "t5");
    repeat (27) step();
    soft_reset_in = 1'b1;
    step();
    soft_reset_in = 1'b0;
    wait_q(60);

    // 6: block reset in DRAIN clears flag and count
    s_tvalid = 1'b1; s_tready = 1'b1; s_tlast = 1'b0;
    step();
    s_tready = 1'b0;
    soft_reset_in = 1'b1;
    e = cyc + 1;
    exp_cnt++;
    exp_at(e, S_CNT,  16'(exp_cnt), "t6_count_pre");
    exp_at(e, S_TO,   16'd1, "t6_flag_pre");
    exp_at(e, S_FIFO, 16'd0, "t6_drain_fifo");
    exp_at(e, S_EN,   16'd0, "t6_en_drop");
    step();
    soft_reset_in = 1'b0;
    repeat (9) step();
    reset_clk1 = 1'b1;
    r = cyc + 1;
    exp_cnt = 0;
    exp_rst_all(r, "t6_reset");
    exp_at(r, S_TO,  16'd0, "t6_flag_clr");
    exp_at(r, S_CNT, 16'd0, "t6_count_clr");
`ifdef RST_SEQ_STATE_PORT_EN
    exp_at(r, S_STATE, 16'd0, "t6_state_hold");
`endif
    step();
    reset_clk1 = 1'b0;
    s_tvalid   = 1'b0;
    exp_release(cyc + 1, "t6");
    wait_q(80);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
